sram_pixel_writer: RTL
======================

SRAM_PIXEL_WRITER -- requirements
Module: sram_pixel_writer

Interface
REQ-001 SHALL have port i_clk  input  1  system clock; all logic sampled on its rising edge.
REQ-002 SHALL have port i_rst_n  input  1  reset; asynchronous assert, active low.
REQ-003 SHALL have port i_spi_sclk  input  1  SPI clock from ESP32, mode 0, asynchronous to i_clk.
REQ-004 SHALL have port i_spi_cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-005 SHALL have port i_spi_mosi  input  1  SPI data, MSB first, asynchronous.
REQ-006 SHALL have port i_waddr_max  input  17  pixels per frame; driven from the LCD controller's max-address output (130560).
REQ-007 SHALL have port o_sram_waddr  output  17  SRAM write address of the pending/next pixel.
REQ-008 SHALL have port o_sram_wdata  output  16  RGB565 pixel to write.
REQ-009 SHALL have port o_sram_wreq  output  1  write request, level, held until acknowledged.
REQ-010 SHALL have port i_sram_wack  input  1  SRAM controller accepted write this cycle.
REQ-011 SHALL have port o_frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-012 SHALL have port o_overrun  output  1  sticky flag: pixel lost because previous write still pending.

Function
REQ-013 SHALL pass i_spi_sclk, i_spi_cs_n, i_spi_mosi through two-flop synchronizers; SCLK edges detected on the synchronized signal; i_clk >= 4x SCLK required.
REQ-014 SHALL shift one MOSI bit into a 16-bit register on each synchronized SCLK rising edge while synchronized CS_n is low.
REQ-015 SHALL keep a 4-bit bit counter; on count 15 -> 0 wrap, a pixel is complete.
REQ-016 SHALL clear bit counter and discard partial bits whenever synchronized CS_n is high; o_sram_waddr unaffected.
REQ-017 SHALL implement states IDLE (o_sram_wreq=0) and PEND (o_sram_wreq=1).
REQ-018 IDLE + pixel complete -> load o_sram_wdata, go PEND; o_sram_wreq rises exactly 4 i_clk edges after the edge first sampling the 16th SCLK rise high.
REQ-019 PEND + i_sram_wack=1 -> o_sram_wreq low next cycle, o_sram_waddr advances, go IDLE.
REQ-020 o_sram_waddr and o_sram_wdata SHALL be stable throughout PEND.
REQ-021 PEND + wack=1 + pixel complete in the same cycle -> old pixel accepted, address advances, new pixel loaded, stay PEND; o_overrun not set.
REQ-022 PEND + pixel complete + wack=0 -> new pixel dropped, pending pixel retained, o_overrun set to 1.
REQ-023 Address advance: if o_sram_waddr == i_waddr_max-1 then wrap to 0 and pulse o_frame_done for one cycle; else increment by 1.
REQ-024 i_sram_wack while IDLE SHALL be ignored.
REQ-025 o_overrun SHALL clear only on reset.

Reset
REQ-026 On i_rst_n low: state IDLE, o_sram_wreq=0, o_sram_waddr=0, o_sram_wdata=0, o_frame_done=0, o_overrun=0, bit counter=0, shift register=0, synchronizers=1 for CS_n and 0 for SCLK/MOSI.
REQ-027 Reset asserted mid-pixel or mid-PEND SHALL abandon the transfer without a write; first pixel after release goes to address 0.

Configuration
REQ-028 Macro PIXEL_WRITER_FRAME_SYNC_EN defined: each synchronized CS_n falling edge sets o_sram_waddr to 0 (if IDLE, next cycle; if PEND, the pending pixel's accept loads 0 instead of incrementing); no o_frame_done pulse from this reset.
REQ-029 Macro not defined: CS_n edges never affect o_sram_waddr; address runs continuously across CS transactions.

Verification
REQ-030 Reset release, CS low, send 0xF800 at SCLK = i_clk/8, wack one cycle after wreq -> wdata=0xF800 at waddr 0, wreq high exactly 4 cycles after 16th edge sampled, waddr=1 afterward.
REQ-031 i_waddr_max=4, send 4 pixels with immediate wack -> addresses 0,1,2,3, o_frame_done single pulse on 4th accept, waddr=0.
REQ-032 Hold wack=0, send 0x1234 then 0xABCD -> wdata stays 0x1234, o_overrun=1; wack=1 -> 0x1234 written, overrun remains 1.
REQ-033 Send 9 bits, raise CS_n, lower, send 0x07E0 -> single write of 0x07E0, no write of partial data.
REQ-034 With PIXEL_WRITER_FRAME_SYNC_EN, write 3 pixels, toggle CS_n, send 0x001F -> written at address 0, no o_frame_done; without macro -> address 3.
REQ-035 Assert i_rst_n low during PEND -> wreq drops immediately, all outputs at REQ-026 values, no wack consumed.

Source files
------------

// File: rtl/sram_pixel_writer.sv
// SPI (mode 0, MSB first) RGB565 pixel receiver that hands each pixel to an SRAM write port.
// Optional build macro PIXEL_WRITER_FRAME_SYNC_EN: a CS_n falling edge restarts addressing at 0.
module sram_pixel_writer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_spi_sclk,
    input  logic        i_spi_cs_n,
    input  logic        i_spi_mosi,
    input  logic [16:0] i_waddr_max,
    output logic [16:0] o_sram_waddr,
    output logic [15:0] o_sram_wdata,
    output logic        o_sram_wreq,
    input  logic        i_sram_wack,
    output logic        o_frame_done,
    output logic        o_overrun
);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;
    logic        r_sclk_prev;
    logic [15:0] r_shift;
    logic [3:0]  r_bit_cnt;
    logic        r_pix_done;
    logic        r_pix_vld;
    logic [15:0] r_pix_word;
    logic [16:0] r_waddr;
    logic [15:0] r_wdata;
    logic        r_frame_done;
    logic        r_overrun;
    logic        w_sclk_rise;
    logic        w_cs_n;
    logic        w_accept;
    logic        w_load;
    logic        w_drop;
    logic        w_addr_last;
    logic        w_wrap;
    logic [16:0] w_addr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_spi_sclk};
            r_cs_sync   <= {r_cs_sync[0], i_spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_cs_n      = r_cs_sync[1];

    // r_pix_vld trails the completing SCLK edge by one extra stage so the
    // request rises a fixed four clocks after the 16th rise is first sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_pix_done <= 1'b0;
            r_pix_vld  <= 1'b0;
            r_pix_word <= '0;
        end else begin
            r_pix_vld <= r_pix_done;
            if (w_cs_n) begin
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_pix_done <= 1'b0;
            end else if (w_sclk_rise) begin
                r_shift    <= {r_shift[14:0], r_mosi_sync[1]};
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_pix_done <= (r_bit_cnt == 4'd15);
                if (r_bit_cnt == 4'd15) begin
                    r_pix_word <= {r_shift[14:0], r_mosi_sync[1]};
                end
            end else begin
                r_pix_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pix_vld) begin
                    w_load       = 1'b1;
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (i_sram_wack) begin
                    w_accept = 1'b1;
                    if (r_pix_vld) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (r_pix_vld) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_addr_last = (r_waddr == (i_waddr_max - 17'd1));

`ifdef PIXEL_WRITER_FRAME_SYNC_EN
    logic r_cs_prev;
    logic r_sync_pend;
    logic w_cs_fall;
    logic w_sync_zero;

    assign w_cs_fall   = r_cs_prev & ~w_cs_n;
    // A restart seen while a pixel is pending is deferred to that pixel's accept.
    assign w_sync_zero = (w_accept & (r_sync_pend | w_cs_fall)) |
                         (w_cs_fall & (r_state == ST_IDLE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_prev   <= 1'b1;
            r_sync_pend <= 1'b0;
        end else begin
            r_cs_prev <= w_cs_n;
            if (w_accept) begin
                r_sync_pend <= 1'b0;
            end else if (w_cs_fall && (r_state == ST_PEND)) begin
                r_sync_pend <= 1'b1;
            end
        end
    end
`else
    logic w_sync_zero;
    assign w_sync_zero = 1'b0;
`endif

    always_comb begin
        w_addr_next = r_waddr;
        w_wrap      = 1'b0;
        if (w_accept) begin
            if (w_addr_last) begin
                w_addr_next = '0;
                w_wrap      = 1'b1;
            end else begin
                w_addr_next = r_waddr + 17'd1;
            end
        end
        if (w_sync_zero) begin
            w_addr_next = '0;
            w_wrap      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_waddr      <= w_addr_next;
            r_frame_done <= w_wrap;
            if (w_load) begin
                r_wdata <= r_pix_word;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_sram_waddr = r_waddr;
    assign o_sram_wdata = r_wdata;
    assign o_sram_wreq  = (r_state == ST_PEND);
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;

endmodule
